csi_packet_sequencer: RTL and testbench



---
 rtl/csi_pkg.sv | 29 ++
 rtl/csi_packet_sequencer_byte_delay_line.sv | 39 +++
 rtl/csi_packet_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_csi_packet_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : csi_pkg
//  Description : Shared types and constants for the CSI-2 transmit path:
//                data-type codes, packet sequencer state encoding and the
//                long-packet word-count helper.
//  Revision    : 1.0  initial release
// ============================================================================
package csi_pkg;

    localparam logic [5:0] DT_FS    = 6'h00;
    localparam logic [5:0] DT_FE    = 6'h01;
    localparam logic [5:0] DT_RAW10 = 6'h2B;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FRAME = 2'd1,
        LINE  = 2'd2
    } seq_state_t;

    // Bytes per line for a given pixel count and bit depth
    function automatic logic [15:0] calc_word_count(input int h_pixels, input int bits_per_pixel);
        int total_bits;
        total_bits = h_pixels * bits_per_pixel;
        return 16'(total_bits / 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/csi_packet_sequencer_byte_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : byte_delay_line
//  Description : Fixed-depth shift register for the {byte_en, byte_data}
//                stream with synchronous clear, so payload bytes line up
//                with the packet header issued by the sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module byte_delay_line #(
    parameter int DEPTH = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_byte_en,
    input  logic [7:0] i_byte_data,
    output logic       o_byte_en,
    output logic [7:0] o_byte_data
);

    logic [8:0] r_stage [DEPTH];

    // Shift one stage per cycle; clear flushes every stage so no stale byte escapes
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= {i_byte_en, i_byte_data};
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign {o_byte_en, o_byte_data} = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/csi_packet_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : csi_packet_sequencer
//  Description : Converts pix2byte frame/line pulses into csi_tx short and
//                long packet controls, delays the byte stream to match the
//                header, retimes the HS-ready handshake and flags malformed
//                frames.
//  Config      : CSI_FRAME_NUMBER_EN - when defined, FS/FE word count
//                carries the frame number; otherwise it is always zero.
//  Revision    : 1.0  initial release
// ============================================================================
module csi_packet_sequencer
    import csi_pkg::*;
#(
    parameter int          H_PIXELS       = 256,
    parameter int          BITS_PER_PIXEL = 10,
    parameter logic [5:0]  DATA_TYPE      = DT_RAW10,
    parameter int          DATA_DELAY     = 3,
    parameter logic [15:0] FRAME_NUM_MAX  = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fv_start,
    input  logic        fv_end,
    input  logic        lv_start,
    input  logic        lv_end,
    input  logic        byte_en_in,
    input  logic [7:0]  byte_data_in,
    input  logic        d_hs_rdy_in,
    output logic        sp_en,
    output logic        lp_en,
    output logic [5:0]  dt,
    output logic [15:0] wc,
    output logic [1:0]  vc,
    output logic        byte_en_out,
    output logic [7:0]  byte_data_out,
    output logic        txfr_en_out,
    output logic [15:0] line_count,
    output logic [15:0] frame_count,
    output logic        wc_error,
    output logic        seq_error
);

    localparam logic [15:0] c_WORD_COUNT = calc_word_count(H_PIXELS, BITS_PER_PIXEL);

    if ((H_PIXELS * BITS_PER_PIXEL) % 8 != 0) begin : g_bad_line_width
        $error("H_PIXELS*BITS_PER_PIXEL must be a whole number of bytes");
    end
    if (DATA_DELAY < 1 || DATA_DELAY > 8) begin : g_bad_data_delay
        $error("DATA_DELAY must be in the range 1..8");
    end

    seq_state_t  r_state, w_state_nxt;
    logic        r_sp_en, w_sp_en_nxt;
    logic        r_lp_en, w_lp_en_nxt;
    logic [5:0]  r_dt, w_dt_nxt;
    logic [15:0] r_wc, w_wc_nxt;
    logic        r_seq_error, w_seq_error_nxt;
    logic        r_wc_error, w_wc_error_nxt;
    logic [15:0] r_line_count, w_line_count_nxt;
    logic [15:0] r_frame_count, w_frame_count_nxt;
    logic [15:0] r_byte_count, w_byte_count_nxt;
    logic        r_txfr_en;

    // Single winning event per cycle: fv_start > fv_end > lv_start > lv_end
    logic w_ev_fs, w_ev_fe, w_ev_ls, w_ev_le;
    assign w_ev_fs = fv_start;
    assign w_ev_fe = fv_end & ~fv_start;
    assign w_ev_ls = lv_start & ~fv_start & ~fv_end;
    assign w_ev_le = lv_end & ~fv_start & ~fv_end & ~lv_start;

    // Frame numbers run 1..FRAME_NUM_MAX and never take the value 0
    logic [15:0] w_frame_num_inc;
    assign w_frame_num_inc = (r_frame_count >= FRAME_NUM_MAX) ? 16'd1 : r_frame_count + 16'd1;

    logic [15:0] w_fs_wc, w_fe_wc;
`ifdef CSI_FRAME_NUMBER_EN
    assign w_fs_wc = w_frame_num_inc;
    assign w_fe_wc = r_frame_count;
`else
    assign w_fs_wc = 16'd0;
    assign w_fe_wc = 16'd0;
`endif

    // Byte count including a byte presented this cycle; saturates at 0xFFFF
    logic [15:0] w_byte_count_now;
    assign w_byte_count_now = (byte_en_in && r_byte_count != 16'hFFFF) ? r_byte_count + 16'd1
                                                                        : r_byte_count;

    // Next-state and packet decode; dt/wc hold between packets
    always_comb begin
        w_state_nxt       = r_state;
        w_sp_en_nxt       = 1'b0;
        w_lp_en_nxt       = 1'b0;
        w_dt_nxt          = r_dt;
        w_wc_nxt          = r_wc;
        w_seq_error_nxt   = 1'b0;
        w_wc_error_nxt    = 1'b0;
        w_line_count_nxt  = r_line_count;
        w_frame_count_nxt = r_frame_count;
        w_byte_count_nxt  = r_byte_count;
        if (w_ev_fs) begin
            // A frame start is legal only between frames, but always opens a new one
            w_seq_error_nxt   = (r_state != IDLE);
            w_sp_en_nxt       = 1'b1;
            w_dt_nxt          = DT_FS;
            w_wc_nxt          = w_fs_wc;
            w_line_count_nxt  = 16'd0;
            w_frame_count_nxt = w_frame_num_inc;
            w_state_nxt       = FRAME;
        end else begin
            case (r_state)
                IDLE: begin
                    w_seq_error_nxt = w_ev_fe | w_ev_ls | w_ev_le;
                end
                FRAME, LINE: begin
                    if (r_state == LINE) begin
                        w_byte_count_nxt = w_byte_count_now;
                    end
                    if (w_ev_fe) begin
                        w_seq_error_nxt = (r_state == LINE);
                        w_sp_en_nxt     = 1'b1;
                        w_dt_nxt        = DT_FE;
                        w_wc_nxt        = w_fe_wc;
                        w_state_nxt     = IDLE;
                    end else if (w_ev_ls) begin
                        // The first payload byte may arrive with the line start
                        w_seq_error_nxt  = (r_state == LINE);
                        w_lp_en_nxt      = 1'b1;
                        w_dt_nxt         = DATA_TYPE;
                        w_wc_nxt         = c_WORD_COUNT;
                        w_byte_count_nxt = {15'd0, byte_en_in};
                        w_state_nxt      = LINE;
                    end else if (w_ev_le) begin
                        if (r_state == LINE) begin
                            w_wc_error_nxt   = (w_byte_count_now != c_WORD_COUNT);
                            w_line_count_nxt = r_line_count + 16'd1;
                            w_state_nxt      = FRAME;
                        end else begin
                            w_seq_error_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // Sequencer state and registered packet controls
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_sp_en       <= 1'b0;
            r_lp_en       <= 1'b0;
            r_dt          <= 6'd0;
            r_wc          <= 16'd0;
            r_seq_error   <= 1'b0;
            r_wc_error    <= 1'b0;
            r_line_count  <= 16'd0;
            r_frame_count <= 16'd0;
            r_byte_count  <= 16'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_sp_en       <= w_sp_en_nxt;
            r_lp_en       <= w_lp_en_nxt;
            r_dt          <= w_dt_nxt;
            r_wc          <= w_wc_nxt;
            r_seq_error   <= w_seq_error_nxt;
            r_wc_error    <= w_wc_error_nxt;
            r_line_count  <= w_line_count_nxt;
            r_frame_count <= w_frame_count_nxt;
            r_byte_count  <= w_byte_count_nxt;
        end
    end

    // HS-ready retimed by one byte clock toward pix2byte
    always_ff @(posedge clk) begin
        if (reset) begin
            r_txfr_en <= 1'b0;
        end else begin
            r_txfr_en <= d_hs_rdy_in;
        end
    end

    byte_delay_line #(
        .DEPTH       (DATA_DELAY)
    ) u_byte_delay_line (
        .clk         (clk),
        .reset       (reset),
        .i_byte_en   (byte_en_in),
        .i_byte_data (byte_data_in),
        .o_byte_en   (byte_en_out),
        .o_byte_data (byte_data_out)
    );

    assign sp_en       = r_sp_en;
    assign lp_en       = r_lp_en;
    assign dt          = r_dt;
    assign wc          = r_wc;
    assign vc          = 2'b00;
    assign txfr_en_out = r_txfr_en;
    assign line_count  = r_line_count;
    assign frame_count = r_frame_count;
    assign wc_error    = r_wc_error;
    assign seq_error   = r_seq_error;

endmodule
`default_nettype wire

// File: tb/tb_csi_packet_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_csi_packet_sequencer
//  Description : Scoreboard bench for csi_packet_sequencer. Directed stimulus
//                pushes expected packets, bytes and error pulses (with the
//                cycle they must appear in); a negedge monitor pops and
//                compares whatever the DUT presents.
//                Honours CSI_FRAME_NUMBER_EN for FS/FE word counts.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_csi_packet_sequencer;
    import csi_pkg::*;

    localparam int          c_DELAY = 3;
    localparam logic [15:0] c_WC    = 16'd320;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fv_start = 1'b0, fv_end = 1'b0, lv_start = 1'b0, lv_end = 1'b0;
    logic        byte_en_in = 1'b0;
    logic [7:0]  byte_data_in = 8'd0;
    logic        d_hs_rdy_in = 1'b0;
    logic        sp_en, lp_en, byte_en_out, txfr_en_out, wc_error, seq_error;
    logic [5:0]  dt;
    logic [15:0] wc, line_count, frame_count;
    logic [1:0]  vc;
    logic [7:0]  byte_data_out;

    csi_packet_sequencer #(
        .H_PIXELS       (256),
        .BITS_PER_PIXEL (10),
        .DATA_TYPE      (6'h2B),
        .DATA_DELAY     (c_DELAY),
        .FRAME_NUM_MAX  (16'd3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .fv_start      (fv_start),
        .fv_end        (fv_end),
        .lv_start      (lv_start),
        .lv_end        (lv_end),
        .byte_en_in    (byte_en_in),
        .byte_data_in  (byte_data_in),
        .d_hs_rdy_in   (d_hs_rdy_in),
        .sp_en         (sp_en),
        .lp_en         (lp_en),
        .dt            (dt),
        .wc            (wc),
        .vc            (vc),
        .byte_en_out   (byte_en_out),
        .byte_data_out (byte_data_out),
        .txfr_en_out   (txfr_en_out),
        .line_count    (line_count),
        .frame_count   (frame_count),
        .wc_error      (wc_error),
        .seq_error     (seq_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec  = 0;
    int n_fail = 0;

    typedef struct { logic sp; logic [5:0] dt; logic [15:0] wc; int at; } pkt_t;
    typedef struct { logic [7:0] data; int at; } byte_t;
    pkt_t  pkt_q[$];
    byte_t byte_q[$];
    int    seq_q[$];
    int    wce_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: compare every presented output against the queue head
    always @(negedge clk) begin
        if (sp_en || lp_en) begin
            if (pkt_q.size() == 0) begin
                check("unexpected_packet", {30'd0, sp_en, lp_en}, 32'd0);
            end else begin
                pkt_t e;
                e = pkt_q.pop_front();
                check("pkt_kind", {30'd0, sp_en, lp_en}, e.sp ? 32'd2 : 32'd1);
                check("pkt_dt", {26'd0, dt}, {26'd0, e.dt});
                check("pkt_wc", {16'd0, wc}, {16'd0, e.wc});
                check("pkt_cycle", cyc, e.at);
                check("pkt_vc", {30'd0, vc}, 32'd0);
            end
        end
        if (pkt_q.size() > 0 && pkt_q[0].at <= cyc) begin
            check("missed_packet_cycle", cyc, pkt_q[0].at - 1);
            void'(pkt_q.pop_front());
        end
        if (byte_en_out) begin
            if (byte_q.size() == 0) begin
                check("unexpected_byte", {31'd0, byte_en_out}, 32'd0);
            end else begin
                byte_t b;
                b = byte_q.pop_front();
                check("byte_data", {24'd0, byte_data_out}, {24'd0, b.data});
                check("byte_cycle", cyc, b.at);
            end
        end
        if (byte_q.size() > 0 && byte_q[0].at <= cyc) begin
            check("missed_byte_cycle", cyc, byte_q[0].at - 1);
            void'(byte_q.pop_front());
        end
        if (seq_error) begin
            if (seq_q.size() == 0) check("unexpected_seq_error", {31'd0, seq_error}, 32'd0);
            else check("seq_error_cycle", cyc, seq_q.pop_front());
        end
        if (seq_q.size() > 0 && seq_q[0] <= cyc) begin
            check("missed_seq_error_cycle", cyc, seq_q[0] - 1);
            void'(seq_q.pop_front());
        end
        if (wc_error) begin
            if (wce_q.size() == 0) check("unexpected_wc_error", {31'd0, wc_error}, 32'd0);
            else check("wc_error_cycle", cyc, wce_q.pop_front());
        end
        if (wce_q.size() > 0 && wce_q[0] <= cyc) begin
            check("missed_wc_error_cycle", cyc, wce_q[0] - 1);
            void'(wce_q.pop_front());
        end
    end

    function automatic logic [15:0] fn_wc(input int n);
`ifdef CSI_FRAME_NUMBER_EN
        return 16'(n);
`else
        return 16'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_pkt(input logic sp, input logic [5:0] d, input logic [15:0] w);
        pkt_t e;
        e.sp = sp; e.dt = d; e.wc = w; e.at = cyc + 1;
        pkt_q.push_back(e);
    endtask

    task automatic ev(input logic fs, input logic fe, input logic ls, input logic le);
        fv_start = fs; fv_end = fe; lv_start = ls; lv_end = le;
        tick();
        fv_start = 1'b0; fv_end = 1'b0; lv_start = 1'b0; lv_end = 1'b0;
    endtask

    // One line: first byte rides with lv_start, lv_end follows the last byte
    task automatic send_line(input int nbytes, input int seed, input bit exp_wc_err, input bit do_end);
        exp_pkt(1'b0, DT_RAW10, c_WC);
        lv_start = 1'b1;
        for (int i = 0; i < nbytes; i++) begin
            byte_t b;
            byte_en_in   = 1'b1;
            byte_data_in = 8'(seed + i * 3);
            b.data = byte_data_in; b.at = cyc + c_DELAY;
            byte_q.push_back(b);
            tick();
            lv_start = 1'b0;
        end
        byte_en_in = 1'b0;
        if (do_end) begin
            if (exp_wc_err) wce_q.push_back(cyc + 1);
            ev(1'b0, 1'b0, 1'b0, 1'b1);
            tick();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_sp_en"}, {31'd0, sp_en}, 32'd0);
        check({tag, "_lp_en"}, {31'd0, lp_en}, 32'd0);
        check({tag, "_dt"}, {26'd0, dt}, 32'd0);
        check({tag, "_wc"}, {16'd0, wc}, 32'd0);
        check({tag, "_vc"}, {30'd0, vc}, 32'd0);
        check({tag, "_byte_en_out"}, {31'd0, byte_en_out}, 32'd0);
        check({tag, "_byte_data_out"}, {24'd0, byte_data_out}, 32'd0);
        check({tag, "_txfr_en_out"}, {31'd0, txfr_en_out}, 32'd0);
        check({tag, "_line_count"}, {16'd0, line_count}, 32'd0);
        check({tag, "_frame_count"}, {16'd0, frame_count}, 32'd0);
        check({tag, "_wc_error"}, {31'd0, wc_error}, 32'd0);
        check({tag, "_seq_error"}, {31'd0, seq_error}, 32'd0);
    endtask

    initial begin
        // Power-on reset
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Frame 1: nominal 8 lines x 320 bytes
        exp_pkt(1'b1, DT_FS, fn_wc(1));
        ev(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        for (int l = 0; l < 8; l++) send_line(320, l * 17, 1'b0, 1'b1);
        check("nominal_line_count", {16'd0, line_count}, 32'd8);
        exp_pkt(1'b1, DT_FE, fn_wc(1));
        ev(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        check("nominal_frame_count", {16'd0, frame_count}, 32'd1);
        check("nominal_line_count_after_fe", {16'd0, line_count}, 32'd8);

        // Frame 2: short line then clean line; FE together with lv_start
        exp_pkt(1'b1, DT_FS, fn_wc(2));
        ev(1'b1, 1'b0, 1'b0, 1'b0);
        send_line(319, 5, 1'b1, 1'b1);
        send_line(320, 9, 1'b0, 1'b1);
        check("short_frame_line_count", {16'd0, line_count}, 32'd2);
        exp_pkt(1'b1, DT_FE, fn_wc(2));
        ev(1'b0, 1'b1, 1'b1, 1'b0);
        tick();

        // lv_start while idle: error pulse, no packet
        seq_q.push_back(cyc + 1);
        ev(1'b0, 1'b0, 1'b1, 1'b0);
        tick();

        // Frames 3 and 4: number wraps 3 -> 1
        exp_pkt(1'b1, DT_FS, fn_wc(3));
        ev(1'b1, 1'b0, 1'b0, 1'b0);
        exp_pkt(1'b1, DT_FE, fn_wc(3));
        ev(1'b0, 1'b1, 1'b0, 1'b0);
        check("frame3_count", {16'd0, frame_count}, 32'd3);
        exp_pkt(1'b1, DT_FS, fn_wc(1));
        ev(1'b1, 1'b0, 1'b0, 1'b0);
        check("wrap_frame_count", {16'd0, frame_count}, 32'd1);
        exp_pkt(1'b1, DT_FE, fn_wc(1));
        ev(1'b0, 1'b1, 1'b0, 1'b0);
        tick();

        // Frame 5: reset at byte 100 of line 3
        d_hs_rdy_in = 1'b1;
        exp_pkt(1'b1, DT_FS, fn_wc(2));
        ev(1'b1, 1'b0, 1'b0, 1'b0);
        send_line(320, 33, 1'b0, 1'b1);
        send_line(320, 44, 1'b0, 1'b1);
        send_line(100, 55, 1'b0, 1'b0);
        while (byte_q.size() > 0 && byte_q[byte_q.size() - 1].at > cyc) void'(byte_q.pop_back());
        reset = 1'b1;
        byte_en_in = 1'b1;
        byte_data_in = 8'hA5;
        tick();
        check_all_zero("midline_reset");
        tick();
        reset = 1'b0;
        byte_en_in = 1'b0;
        d_hs_rdy_in = 1'b0;
        for (int i = 0; i < c_DELAY; i++) begin
            tick();
            check("flushed_byte_en_out", {31'd0, byte_en_out}, 32'd0);
        end

        // Frame 6: numbering restarts at 1; fv_end mid-line is an error with FE
        exp_pkt(1'b1, DT_FS, fn_wc(1));
        ev(1'b1, 1'b0, 1'b0, 1'b0);
        check("post_reset_frame_count", {16'd0, frame_count}, 32'd1);
        send_line(5, 77, 1'b0, 1'b0);
        seq_q.push_back(cyc + 1);
        exp_pkt(1'b1, DT_FE, fn_wc(1));
        ev(1'b0, 1'b1, 1'b0, 1'b0);
        check("fe_in_line_line_count", {16'd0, line_count}, 32'd0);
        tick();

        // Handshake retiming
        for (int i = 0; i < 32; i++) begin
            logic v;
            v = 1'($urandom_range(0, 1));
            d_hs_rdy_in = v;
            tick();
            check("txfr_en_out", {31'd0, txfr_en_out}, {31'd0, v});
        end

        repeat (6) tick();
        check("pkt_queue_drained", pkt_q.size(), 32'd0);
        check("byte_queue_drained", byte_q.size(), 32'd0);
        check("seq_queue_drained", seq_q.size(), 32'd0);
        check("wce_queue_drained", wce_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
